// File: rtl/aes_word_loader_if.sv
// Host-side word bus for the AES word loader: valid/ready transfer of one
// word tagged as key or data, plus the cipher direction for the block.
interface aes_word_loader_if #(
    parameter int unsigned WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              in_is_key;
    logic              in_mode;

    modport master (
        output in_valid,
        output in_word,
        output in_is_key,
        output in_mode,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_word,
        input  in_is_key,
        input  in_mode,
        output in_ready
    );
endinterface

// File: rtl/aes_word_loader.sv
// AES-128 front-end: shifts host words into the key/data block registers and
// launches one core operation per completed data block, with a done-timeout.
module aes_word_loader #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    aes_word_loader_if.slave   host,
    input  logic               flush,
    input  logic               core_done,
    output logic               start,
    output logic               key_change,
    output logic               sel_cypher,
    output logic [BLOCK_W-1:0] key_out,
    output logic [BLOCK_W-1:0] data_out,
    output logic               err_nokey,
    output logic               err_timeout
);
    localparam int unsigned NWORDS = BLOCK_W / WORD_W;
    localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY
    } state_e;

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]   key_cnt_q, key_cnt_d;
    logic [CNT_W-1:0]   data_cnt_q, data_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               key_loaded_q, key_loaded_d;
    logic               key_dirty_q, key_dirty_d;
    logic               sel_cypher_q, sel_cypher_d;
    logic               in_ready_q, in_ready_d;
    logic               err_nokey_q, err_nokey_d;
    logic               err_timeout_q, err_timeout_d;
    logic               xfer;

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        data_d        = data_q;
        key_cnt_d     = key_cnt_q;
        data_cnt_d    = data_cnt_q;
        timer_d       = '0;
        key_loaded_d  = key_loaded_q;
        key_dirty_d   = key_dirty_q;
        sel_cypher_d  = sel_cypher_q;
        err_nokey_d   = 1'b0;
        err_timeout_d = 1'b0;
        // flush wins over a same-cycle transfer, which is simply dropped
        xfer = host.in_valid && in_ready_q && (state_q == ST_IDLE) && !flush;

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    key_cnt_d  = '0;
                    data_cnt_d = '0;
                end else if (xfer) begin
                    if (host.in_is_key) begin
                        key_d = {key_q[BLOCK_W-WORD_W-1:0], host.in_word};
                        if (key_cnt_q == CNT_W'(NWORDS - 1)) begin
                            key_cnt_d    = '0;
                            key_loaded_d = 1'b1;
                            key_dirty_d  = 1'b1;
                        end else begin
                            key_cnt_d = key_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        data_d = {data_q[BLOCK_W-WORD_W-1:0], host.in_word};
                        if (data_cnt_q == CNT_W'(NWORDS - 1)) begin
                            data_cnt_d   = '0;
                            sel_cypher_d = host.in_mode;
                            if (key_loaded_q) begin
                                state_d = ST_START;
                            end else begin
                                err_nokey_d = 1'b1;
                            end
                        end else begin
                            data_cnt_d = data_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            ST_START: begin
                key_dirty_d = 1'b0;
                state_d     = ST_BUSY;
            end
            ST_BUSY: begin
                if (core_done) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // ready is registered so it reads 0 while reset is held
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            key_q         <= '0;
            data_q        <= '0;
            key_cnt_q     <= '0;
            data_cnt_q    <= '0;
            timer_q       <= '0;
            key_loaded_q  <= 1'b0;
            key_dirty_q   <= 1'b0;
            sel_cypher_q  <= 1'b0;
            in_ready_q    <= 1'b0;
            err_nokey_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            data_q        <= data_d;
            key_cnt_q     <= key_cnt_d;
            data_cnt_q    <= data_cnt_d;
            timer_q       <= timer_d;
            key_loaded_q  <= key_loaded_d;
            key_dirty_q   <= key_dirty_d;
            sel_cypher_q  <= sel_cypher_d;
            in_ready_q    <= in_ready_d;
            err_nokey_q   <= err_nokey_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign host.in_ready = in_ready_q;
    assign start         = (state_q == ST_START);
    assign key_change    = (state_q == ST_START) && key_dirty_q;
    assign sel_cypher    = sel_cypher_q;
    assign key_out       = key_q;
    assign data_out      = data_q;
    assign err_nokey     = err_nokey_q;
    assign err_timeout   = err_timeout_q;
endmodule

// File: tb/tb_aes_word_loader.sv
// Directed bench for aes_word_loader: expected core launches and error pulses
// are queued by the stimulus and matched by a monitor as the DUT emits them.
module tb_aes_word_loader;
    logic         clk;
    logic         reset;
    logic         flush;
    logic         core_done;
    logic         start;
    logic         key_change;
    logic         sel_cypher;
    logic [127:0] key_out;
    logic [127:0] data_out;
    logic         err_nokey;
    logic         err_timeout;

    aes_word_loader_if #(.WORD_W(32)) host ();

    aes_word_loader #(
        .WORD_W (32),
        .BLOCK_W(128),
        .TIMEOUT(64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .host       (host),
        .flush      (flush),
        .core_done  (core_done),
        .start      (start),
        .key_change (key_change),
        .sel_cypher (sel_cypher),
        .key_out    (key_out),
        .data_out   (data_out),
        .err_nokey  (err_nokey),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   kind;   // {start, err_nokey, err_timeout}
        logic         kc;
        logic         sel;
        logic [127:0] key;
        logic [127:0] data;
    } exp_t;

    localparam logic [2:0] EV_START   = 3'b100;
    localparam logic [2:0] EV_NOKEY   = 3'b010;
    localparam logic [2:0] EV_TIMEOUT = 3'b001;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] kind, input logic kc, input logic sel,
                        input logic [127:0] k, input logic [127:0] d);
        exp_t e;
        e.kind = kind; e.kc = kc; e.sel = sel; e.key = k; e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset && (start || err_nokey || err_timeout)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {125'd0, start, err_nokey, err_timeout}, 128'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_kind", {125'd0, start, err_nokey, err_timeout}, {125'd0, e.kind});
                if (e.kind == EV_START) begin
                    check("key_change", {127'd0, key_change}, {127'd0, e.kc});
                    check("sel_cypher", {127'd0, sel_cypher}, {127'd0, e.sel});
                    check("key_out", key_out, e.key);
                    check("data_out", data_out, e.data);
                end
            end
        end
    end

    // Presents one word from posedge+1 and returns #1 after the accepting edge.
    task automatic send(input logic [31:0] w, input logic is_key, input logic mode);
        int n;
        host.in_valid  = 1'b1;
        host.in_word   = w;
        host.in_is_key = is_key;
        host.in_mode   = mode;
        n = 0;
        while (!host.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("send_ready_timeout", 128'd0, 128'd1);
        @(posedge clk); #1;
        host.in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] b, input logic is_key, input logic mode);
        logic [127:0] v;
        v = b;
        for (int unsigned i = 0; i < 4; i++) begin
            send(v[127:96], is_key, mode);
            v = v << 32;
        end
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 core_done = 1'b1;
        @(posedge clk); #1 core_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [127:0] k1, d1, d2, d3, k2, f1, g1;
    int n;

    initial begin
        k1 = 128'h000102030405060708090A0B0C0D0E0F;
        d1 = 128'h00112233445566778899AABBCCDDEEFF;
        d2 = 128'hDEADBEEF111111112222222233333333;
        d3 = 128'hA0A0A0A0A1A1A1A1A2A2A2A2A3A3A3A3;
        k2 = 128'h0F0E0D0C0B0A09080706050403020100;
        f1 = 128'hF0F0F0F0F1F1F1F1F2F2F2F2F3F3F3F3;
        g1 = 128'h55555555666666667777777788888888;

        reset = 1'b0; flush = 1'b0; core_done = 1'b0;
        host.in_valid = 1'b0; host.in_word = '0; host.in_is_key = 1'b0; host.in_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {122'd0, host.in_ready, start, key_change, sel_cypher, err_nokey, err_timeout}, 128'd0);
        check("rst_key", key_out, 128'd0);
        check("rst_data", data_out, 128'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", {127'd0, host.in_ready}, 128'd1);

        // 1: key then data, encrypt
        send_block(k1, 1'b1, 1'b0);
        push(EV_START, 1'b1, 1'b1, k1, d1);
        send_block(d1, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_start_latency", {127'd0, start}, 128'd1);

        // 4: hold a word during BUSY
        @(posedge clk); #1;
        host.in_valid = 1'b1; host.in_word = 32'hDEADBEEF; host.in_is_key = 1'b0; host.in_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_busy_ready", {127'd0, host.in_ready}, 128'd0);
        check("t4_busy_data", data_out, d1);
        check("t4_busy_sel", {127'd0, sel_cypher}, 128'd1);
        pulse_done();
        check("t4_ready_after_done", {127'd0, host.in_ready}, 128'd1);
        @(posedge clk); #1 host.in_valid = 1'b0;
        check("t4_pending_accepted", data_out, {d1[95:0], 32'hDEADBEEF});

        // 2: data only, decrypt, key unchanged
        push(EV_START, 1'b0, 1'b0, k1, d2);
        send(32'h11111111, 1'b0, 1'b0);
        send(32'h22222222, 1'b0, 1'b0);
        send(32'h33333333, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_start", {127'd0, start}, 128'd1);
        repeat (2) @(posedge clk);
        pulse_done();
        pulse_done();
        repeat (3) @(negedge clk);
        check("done_in_idle_no_start", {127'd0, start}, 128'd0);

        // 5: timeout
        push(EV_START, 1'b0, 1'b1, k1, d3);
        push(EV_TIMEOUT, 1'b0, 1'b0, '0, '0);
        send_block(d3, 1'b0, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_timeout && n < 200);
        check("t5_timeout_cycles", n, 66);
        check("t5_idle_ready", {127'd0, host.in_ready}, 128'd1);

        // 3: from reset, data without key
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        push(EV_NOKEY, 1'b0, 1'b0, '0, '0);
        send_block(d1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("t3_no_start", {127'd0, start}, 128'd0);

        // 6: partial load, flush drops a word and clears the counter
        send(32'hE0E0E0E0, 1'b0, 1'b0);
        send(32'hE1E1E1E1, 1'b0, 1'b0);
        host.in_valid = 1'b1; host.in_word = 32'hBADBAD00; host.in_is_key = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; host.in_valid = 1'b0;
        push(EV_NOKEY, 1'b0, 1'b0, '0, '0);
        send_block(f1, 1'b0, 1'b0);
        @(negedge clk);
        check("t6_flush_data", data_out, f1);

        send_block(k2, 1'b1, 1'b0);
        push(EV_START, 1'b1, 1'b1, k2, g1);
        send_block(g1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_rst_busy_ctrl", {122'd0, host.in_ready, start, key_change, sel_cypher, err_nokey, err_timeout}, 128'd0);
        check("t6_rst_busy_key", key_out, 128'd0);
        check("t6_rst_busy_data", data_out, 128'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
